// File: rtl/ldmx_link_tx.sv
// ldmx_link_tx: transmit end of the front-end DAQ link.
// Frames variable-length events from a valid/ready word stream onto a 32-bit
// K-character link: idles, SOE, header, payload, trailer, checksum, EOE.
module ldmx_link_tx #(
  parameter int MAX_WORDS = 2048,
  parameter int IDLE_GAP  = 4
) (
  input  logic        clk_link,
  input  logic        reset,
  input  logic [7:0]  fpga_id,
  input  logic [31:0] evt_data,
  input  logic        evt_valid,
  input  logic        evt_last,
  output logic        evt_ready,
  output logic [31:0] link_data,
  output logic [3:0]  link_is_k,
  output logic        link_valid,
  output logic        busy,
  output logic [31:0] evt_count,
  output logic [15:0] trunc_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOE,
    S_HDR,
    S_PAYLOAD,
    S_TRL,
    S_CSUM,
    S_EOE,
    S_GAP
  } state_t;

  localparam logic [31:0] K_IDLE   = 32'h000000BC;
  localparam logic [31:0] K_SOE    = 32'h000000FB;
  localparam logic [31:0] K_EOE    = 32'h000000FD;
  localparam logic [3:0]  K_FLAG   = 4'b0001;
  localparam logic [15:0] MAX_W    = 16'(MAX_WORDS);
  localparam logic [7:0]  GAP_LAST = 8'(IDLE_GAP - 1);

  state_t      state, state_d;
  logic [15:0] nwords, nwords_d;
  logic [31:0] csum, csum_d;
  logic        trunc, trunc_d;
  logic [7:0]  gap_cnt, gap_cnt_d;
  logic [7:0]  id_q, id_d;
  logic [15:0] evt_seq, evt_seq_d;
  logic [31:0] evt_count_d;
  logic [15:0] trunc_count_d;
  logic [31:0] link_data_d;
  logic [3:0]  link_is_k_d;
  logic        accept;

  // Ready and busy depend only on the registered state, never on evt_valid.
  assign evt_ready = (state == S_PAYLOAD);
  assign busy      = (state != S_IDLE);
  assign accept    = evt_valid && evt_ready;

  // State register.
  always_ff @(posedge clk_link) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state, next link word and next datapath values for the current state.
  always_comb begin
    state_d       = state;
    link_data_d   = K_IDLE;
    link_is_k_d   = K_FLAG;
    nwords_d      = nwords;
    csum_d        = csum;
    trunc_d       = trunc;
    gap_cnt_d     = gap_cnt;
    id_d          = id_q;
    evt_seq_d     = evt_seq;
    evt_count_d   = evt_count;
    trunc_count_d = trunc_count;
    case (state)
      S_IDLE: begin
        if (evt_valid) state_d = S_SOE;
      end
      S_SOE: begin
        link_data_d = K_SOE;
        id_d        = fpga_id;
        nwords_d    = 16'd0;
        csum_d      = 32'd0;
        trunc_d     = 1'b0;
        state_d     = S_HDR;
      end
      S_HDR: begin
        link_data_d = {8'hA5, id_q, evt_seq};
        link_is_k_d = 4'b0000;
        state_d     = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (accept) begin
          if (nwords < MAX_W) begin
            link_data_d = evt_data;
            link_is_k_d = 4'b0000;
            nwords_d    = nwords + 16'd1;
            csum_d      = csum + evt_data;
          end else begin
            trunc_d = 1'b1;
          end
          if (evt_last) state_d = S_TRL;
        end
      end
      S_TRL: begin
        link_data_d = {trunc, 15'h0, nwords};
        link_is_k_d = 4'b0000;
        state_d     = S_CSUM;
      end
      S_CSUM: begin
        link_data_d = csum;
        link_is_k_d = 4'b0000;
        state_d     = S_EOE;
      end
      S_EOE: begin
        link_data_d = K_EOE;
        evt_count_d = evt_count + 32'd1;
        evt_seq_d   = evt_seq + 16'd1;
        if (trunc && (trunc_count != 16'hFFFF)) trunc_count_d = trunc_count + 16'd1;
        gap_cnt_d   = 8'd0;
        state_d     = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_IDLE;
        else                     gap_cnt_d = gap_cnt + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered link outputs, counters and per-event datapath.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      link_data   <= 32'd0;
      link_is_k   <= 4'd0;
      link_valid  <= 1'b0;
      nwords      <= 16'd0;
      csum        <= 32'd0;
      trunc       <= 1'b0;
      gap_cnt     <= 8'd0;
      id_q        <= 8'd0;
      evt_seq     <= 16'd0;
      evt_count   <= 32'd0;
      trunc_count <= 16'd0;
    end else begin
      link_data   <= link_data_d;
      link_is_k   <= link_is_k_d;
      link_valid  <= 1'b1;
      nwords      <= nwords_d;
      csum        <= csum_d;
      trunc       <= trunc_d;
      gap_cnt     <= gap_cnt_d;
      id_q        <= id_d;
      evt_seq     <= evt_seq_d;
      evt_count   <= evt_count_d;
      trunc_count <= trunc_count_d;
    end
  end

endmodule
